// File: rtl/ro_puf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ro_puf_pkg
//  Description : Shared FSM state encoding and default constants for the
//                ring-oscillator PUF sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ro_puf_pkg;

    localparam int c_num_ro_dflt     = 16;
    localparam int c_cnt_w_dflt      = 16;
    localparam int c_win_w_dflt      = 16;
    localparam int c_settle_cyc_dflt = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        COUNT   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } ro_puf_state_t;

endpackage
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ro_edge_counter
//  Description : Synchronizes one raw oscillator output, detects rising edges
//                and counts them while enabled. RO_PUF_SAT_EN selects a
//                saturating counter; otherwise the count wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_dflt
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] cnt
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;
    logic             w_inc;

    // ro_in is asynchronous to clk; two flops before anything looks at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;

`ifdef RO_PUF_SAT_EN
    assign w_inc = cnt_en & w_rise & ~(&r_cnt);
`else
    assign w_inc = cnt_en & w_rise;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (w_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ro_puf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ro_puf_ctrl
//  Description : Ring-oscillator PUF sequencer: enables an oscillator pair,
//                counts edges over a programmable window and compares them.
//                RO_PUF_SAT_EN (in ro_edge_counter) selects saturating counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO     = c_num_ro_dflt,
    parameter int SEL_W      = $clog2(NUM_RO),
    parameter int CNT_W      = c_cnt_w_dflt,
    parameter int WIN_W      = c_win_w_dflt,
    parameter int SETTLE_CYC = c_settle_cyc_dflt
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    input  logic [WIN_W-1:0]  win_cycles,
    input  logic [NUM_RO-1:0] ro_out,
    output logic [NUM_RO-1:0] ro_en,
    output logic              busy,
    output logic              done,
    output logic              response,
    output logic              err,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    localparam int               c_set_w    = $clog2(SETTLE_CYC);
    localparam int               c_tmr_w    = (WIN_W > c_set_w) ? WIN_W : c_set_w;
    localparam logic [SEL_W:0]   c_num_ro_w = (SEL_W + 1)'(NUM_RO);

    ro_puf_state_t     r_state;
    ro_puf_state_t     w_next;

    logic [SEL_W-1:0]  r_sel_a;
    logic [SEL_W-1:0]  r_sel_b;
    logic [SEL_W-1:0]  w_sel_a_nxt;
    logic [SEL_W-1:0]  w_sel_b_nxt;
    logic [WIN_W-1:0]  r_win;
    logic [c_tmr_w-1:0] r_timer;

    logic              w_accept;
    logic              w_illegal;
    logic              w_settle_end;
    logic              w_count_end;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_active_nxt;

    logic [NUM_RO-1:0] w_oh_nxt;
    logic [NUM_RO-1:0] w_oh_a;
    logic [NUM_RO-1:0] w_oh_b;
    logic [NUM_RO-1:0] r_ro_en;
    logic              w_ro_a;
    logic              w_ro_b;

    logic [CNT_W-1:0]  w_cnt_a;
    logic [CNT_W-1:0]  w_cnt_b;
    logic [CNT_W-1:0]  r_cnt_a;
    logic [CNT_W-1:0]  r_cnt_b;
    logic              r_resp;
    logic              r_err;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_illegal = (sel_a == sel_b)
                     || ({1'b0, sel_a} >= c_num_ro_w)
                     || ({1'b0, sel_b} >= c_num_ro_w);

    assign w_settle_end = (r_timer == c_tmr_w'(SETTLE_CYC - 1));
    assign w_count_end  = (r_timer == (c_tmr_w'(r_win) - c_tmr_w'(1)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_illegal ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                if (w_settle_end) begin
                    w_next = (r_win == '0) ? COMPARE : COUNT;
                end
            end
            COUNT: begin
                if (w_count_end) begin
                    w_next = COMPARE;
                end
            end
            COMPARE: w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (r_state != IDLE);
        done         = (r_state == DONE);
        w_cnt_clr    = (r_state == SETTLE);
        w_cnt_en     = (r_state == COUNT);
        w_active_nxt = (w_next == SETTLE) || (w_next == COUNT);
    end

    // Window/settle timer restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || (w_next != r_state)) begin
            r_timer <= '0;
        end else if (w_cnt_clr || w_cnt_en) begin
            r_timer <= r_timer + c_tmr_w'(1);
        end
    end

    assign w_sel_a_nxt = w_accept ? sel_a : r_sel_a;
    assign w_sel_b_nxt = w_accept ? sel_b : r_sel_b;

    always_comb begin
        w_oh_nxt = '0;
        w_oh_a   = '0;
        w_oh_b   = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            w_oh_nxt[i] = (w_sel_a_nxt == SEL_W'(i)) || (w_sel_b_nxt == SEL_W'(i));
            w_oh_a[i]   = (r_sel_a == SEL_W'(i));
            w_oh_b[i]   = (r_sel_b == SEL_W'(i));
        end
    end

    // Only the selected pair reaches the synchronizers.
    assign w_ro_a = |(ro_out & w_oh_a);
    assign w_ro_b = |(ro_out & w_oh_b);

    // Enables come straight from a flop so the oscillator bank never sees
    // decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ro_en <= '0;
            r_sel_a <= '0;
            r_sel_b <= '0;
            r_win   <= '0;
            r_resp  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            r_ro_en <= w_active_nxt ? w_oh_nxt : '0;
            if (w_accept) begin
                r_sel_a <= sel_a;
                r_sel_b <= sel_b;
                r_win   <= win_cycles;
                r_err   <= w_illegal;
                r_resp  <= 1'b0;
                r_cnt_a <= '0;
                r_cnt_b <= '0;
            end else if (r_state == COMPARE) begin
                r_cnt_a <= w_cnt_a;
                r_cnt_b <= w_cnt_b;
                r_resp  <= (w_cnt_a > w_cnt_b);
            end
        end
    end

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .ro_in  (w_ro_a),
        .clr    (w_cnt_clr),
        .cnt_en (w_cnt_en),
        .cnt    (w_cnt_a)
    );

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .ro_in  (w_ro_b),
        .clr    (w_cnt_clr),
        .cnt_en (w_cnt_en),
        .cnt    (w_cnt_b)
    );

    assign ro_en    = r_ro_en;
    assign response = r_resp;
    assign err      = r_err;
    assign cnt_a    = r_cnt_a;
    assign cnt_b    = r_cnt_b;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ro_puf_ctrl
//  Description : Self-checking bench for ro_puf_ctrl with modelled oscillators.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_puf_ctrl;

    localparam int NR = 12;
    localparam int SW = 4;
    localparam int CW = 16;
    localparam int WW = 16;
    localparam int SC = 8;

    typedef struct {
        int sa; int sb; int win;
        int alo; int ahi; int blo; int bhi;
        int resp; int err; int lat;
        bit chkc; bit eq;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] sel_a = '0;
    logic [SW-1:0] sel_b = '0;
    logic [WW-1:0] win_cycles = '0;
    logic [NR-1:0] ro_out = '0;
    logic [NR-1:0] ro_en;
    logic          busy, done, response, err;
    logic [CW-1:0] cnt_a, cnt_b;

    logic          s_start = 1'b0;
    logic [1:0]    s_sel_a = '0;
    logic [1:0]    s_sel_b = '0;
    logic [WW-1:0] s_win = '0;
    logic [3:0]    s_ro = '0;
    logic [3:0]    s_ro_en;
    logic          s_busy, s_done, s_resp, s_err;
    logic [3:0]    s_cnt_a, s_cnt_b;

    int            checks = 0;
    int            errors = 0;
    int            en_viol = 0;
    logic [NR-1:0] exp_mask = '0;
    int            ro_per [NR] = '{10, 14, 10, 10, 14, 14, 10, 12, 12, 10, 10, 10};
    vec_t          vecs [8];
    vec_t          sb_q [$];

    ro_puf_ctrl #(
        .NUM_RO(NR), .SEL_W(SW), .CNT_W(CW), .WIN_W(WW), .SETTLE_CYC(SC)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b),
        .win_cycles(win_cycles), .ro_out(ro_out), .ro_en(ro_en), .busy(busy),
        .done(done), .response(response), .err(err), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    ro_puf_ctrl #(
        .NUM_RO(4), .SEL_W(2), .CNT_W(4), .WIN_W(WW), .SETTLE_CYC(SC)
    ) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .sel_a(s_sel_a), .sel_b(s_sel_b),
        .win_cycles(s_win), .ro_out(s_ro), .ro_en(s_ro_en), .busy(s_busy),
        .done(s_done), .response(s_resp), .err(s_err), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
    );

    always #5 clk = ~clk;

    // Oscillator model: period in clk cycles, all phases aligned to time 0.
    always #1 begin
        for (int i = 0; i < NR; i++) begin
            ro_out[i] = (($time % longint'(ro_per[i] * 10)) < longint'(ro_per[i] * 5));
        end
        s_ro[0] = (($time % 40) < 20);
        s_ro[1] = (($time % 80) < 40);
        s_ro[3:2] = 2'b00;
    end

    always @(negedge clk) begin
        if (!rst && ro_en != '0 && ro_en != exp_mask) en_viol++;
    end

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic vec_t mk(int sa, int sb, int win, int alo, int ahi, int blo, int bhi,
                                int resp, int err_v, bit chkc, bit eq);
        vec_t v;
        v.sa = sa; v.sb = sb; v.win = win;
        v.alo = alo; v.ahi = ahi; v.blo = blo; v.bhi = bhi;
        v.resp = resp; v.err = err_v; v.chkc = chkc; v.eq = eq;
        v.lat = err_v ? 1 : (SC + win + 2);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int poke, input string tag);
        int            lat;
        int            v0;
        vec_t          e;
        logic [NR-1:0] m;
        @(posedge clk); #1;
        sel_a = SW'(v.sa); sel_b = SW'(v.sb); win_cycles = WW'(v.win); start = 1'b1;
        for (int i = 0; i < NR; i++) m[i] = (i == v.sa) || (i == v.sb);
        exp_mask = v.err ? '0 : m;
        sb_q.push_back(v);
        v0 = en_viol;
        @(posedge clk); #1;
        start = 1'b0; sel_a = ~sel_a; sel_b = ~sel_b; win_cycles = '1;
        chk({tag, "_busy_t1"}, busy, 1, 1);
        lat = 1;
        while (!done && lat < 3000) begin
            if (lat == poke) begin
                start = 1'b1; sel_a = SW'(v.sb); sel_b = SW'(v.sa); win_cycles = WW'(5);
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        e = sb_q.pop_front();
        chk({tag, "_latency"}, lat, e.lat, e.lat);
        chk({tag, "_err"}, err, e.err, e.err);
        chk({tag, "_response"}, response, e.resp, e.resp);
        if (e.chkc) begin
            chk({tag, "_cnt_a"}, cnt_a, e.alo, e.ahi);
            chk({tag, "_cnt_b"}, cnt_b, e.blo, e.bhi);
        end
        if (e.eq) chk({tag, "_cnt_equal"}, int'(cnt_a) - int'(cnt_b), 0, 0);
        chk({tag, "_ro_en_pair"}, en_viol - v0, 0, 0);
        @(posedge clk); #1;
        chk({tag, "_busy_fall"}, busy, 0, 0);
        chk({tag, "_response_hold"}, response, e.resp, e.resp);
    endtask

    initial begin
        int lat;
        vecs[0] = mk(2, 5, 1400, 139, 141, 99, 101, 1, 0, 1, 0);
        vecs[1] = mk(5, 2, 1400, 99, 101, 139, 141, 0, 0, 1, 0);
        vecs[2] = mk(7, 8, 600, 49, 51, 49, 51, 0, 0, 1, 1);
        vecs[3] = mk(3, 3, 100, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[4] = mk(12, 1, 100, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[5] = mk(1, 12, 100, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[6] = mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7] = mk(2, 5, 100, 9, 11, 6, 8, 1, 0, 1, 0);

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ro_en", ro_en, 0, 0);
        chk("rst_busy", busy, 0, 0);
        chk("rst_done", done, 0, 0);
        chk("rst_response", response, 0, 0);
        chk("rst_err", err, 0, 0);
        chk("rst_cnt_a", cnt_a, 0, 0);
        chk("rst_cnt_b", cnt_b, 0, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

        // start pulsed mid-run must not disturb the ongoing evaluation
        run_vec(vecs[0], 100, "ignored_start");

        // reset in the middle of the counting window
        @(posedge clk); #1;
        sel_a = 4'd2; sel_b = 4'd5; win_cycles = WW'(1400); start = 1'b1;
        exp_mask = 12'h024;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ro_en", ro_en, 0, 0);
        chk("midrst_busy", busy, 0, 0);
        chk("midrst_done", done, 0, 0);
        chk("midrst_response", response, 0, 0);
        chk("midrst_err", err, 0, 0);
        chk("midrst_cnt_a", cnt_a, 0, 0);
        rst = 1'b0;
        run_vec(vecs[7], 0, "recover");

        // narrow counters on the second instance
        @(posedge clk); #1;
        s_sel_a = 2'd0; s_sel_b = 2'd1; s_win = WW'(200); s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        lat = 1;
        while (!s_done && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("sat_latency", lat, SC + 202, SC + 202);
        chk("sat_response", s_resp, 0, 0);
`ifdef RO_PUF_SAT_EN
        chk("sat_cnt_a", s_cnt_a, 15, 15);
        chk("sat_cnt_b", s_cnt_b, 15, 15);
`else
        chk("wrap_cnt_a", s_cnt_a, 1, 3);
        chk("wrap_cnt_b", s_cnt_b, 8, 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ro_puf_ctrl.md
# ro_puf_ctrl

Sequencer for the ring-oscillator PUF array. For each challenge it enables exactly two ring oscillators, counts their rising edges over a programmable window in the system clock domain, and compares the counts to produce one response bit. It sits between the challenge/response host logic and the bank of `ro` instances, and it owns every `en` input of that bank.

## Interface
Parameters:
- `NUM_RO`, 16: number of ring oscillators in the bank; must be ≥ 2.
- `SEL_W`, `$clog2(NUM_RO)`: width of each oscillator index.
- `CNT_W`, 16: edge-counter width.
- `WIN_W`, 16: width of the window-length input.
- `SETTLE_CYC`, 8: cycles the oscillators run before counting starts; must be ≥ 4.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle evaluation request; sampled only in IDLE.
- `sel_a` in SEL_W: index of the first oscillator; latched on an accepted `start`.
- `sel_b` in SEL_W: index of the second oscillator; latched on an accepted `start`.
- `win_cycles` in WIN_W: counting-window length in clk cycles; latched on an accepted `start`.
- `ro_out` in NUM_RO: raw `roout` of each oscillator; asynchronous.
- `ro_en` out NUM_RO: one-hot-pair enables to the oscillator bank.
- `busy` out 1: high from accept until `done`, inclusive.
- `done` out 1: one-cycle completion pulse.
- `response` out 1: PUF bit, 1 iff count_a > count_b.
- `err` out 1: last request was illegal.
- `cnt_a` out CNT_W: final edge count of oscillator `sel_a`.
- `cnt_b` out CNT_W: final edge count of oscillator `sel_b`.

## Operation
- FSM states: IDLE → SETTLE → COUNT → COMPARE → DONE → IDLE.
- IDLE:
  - `start`=1 latches `sel_a`, `sel_b` and `win_cycles`.
  - If `sel_a`==`sel_b` or either index ≥ NUM_RO, go directly to DONE with `err`=1 and `response`=0. No `ro_en` bit is ever raised for an illegal request.
  - Otherwise clear `err` and go to SETTLE.
- SETTLE:
  - `ro_en[sel_a]` and `ro_en[sel_b]` are high; all other bits are low.
  - Both counters are cleared.
  - Lasts exactly SETTLE_CYC cycles. This also flushes the synchronizers.
- COUNT:
  - Lasts exactly `win_cycles` cycles. If `win_cycles`=0, the block skips to COMPARE and both counts are 0.
  - Each counter increments once for every rising edge detected on its synchronized oscillator output.
- COMPARE:
  - `ro_en` goes all zero.
  - `cnt_a`, `cnt_b` and `response` (strict >) are registered. A tie gives 0.
- DONE: `done`=1 for one cycle, then the FSM returns to IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- `response`, `err`, `cnt_a` and `cnt_b` hold their values until the next accepted `start`.
- Oscillator outputs: each passes through a 2-flop synchronizer, then a registered previous-value rising-edge detect.
- Oscillator frequency requirement: frequency after the mux must be < f_clk/2. Faster oscillators alias, and this is a documented integration constraint rather than a detected fault.
- Only the two selected `ro_out` lines are muxed into the counting path.
- Reset mid-operation: the FSM returns to IDLE and `ro_en` is all zero on the next edge. Any partial result is discarded.

## Timing
- Reset values: `ro_en`=0, `busy`=0, `done`=0, `response`=0, `err`=0, `cnt_a`=0, `cnt_b`=0, FSM in IDLE.
- Legal request with `start` accepted at edge T:
  - `busy` and `ro_en` are high from T+1.
  - COUNT occupies T+1+SETTLE_CYC through T+SETTLE_CYC+W, where W = `win_cycles`.
  - COMPARE is at T+SETTLE_CYC+W+1.
  - `done` is at T+SETTLE_CYC+W+2.
- Illegal request accepted at T: `done` and `err` at T+1.
- Edge-detect latency is 3 cycles. The window is shifted by a constant, identical for both oscillators.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that same cycle.

## Configuration
- `RO_PUF_SAT_EN` defined: counters saturate at 2^CNT_W−1. If both counts saturate, the result is a tie, so `response`=0.
- `RO_PUF_SAT_EN` undefined: counters wrap modulo 2^CNT_W. The compare uses the wrapped values.

## Structure
- Shared package `ro_puf_pkg` holds:
  - the FSM state enum `ro_puf_state_t` (IDLE, SETTLE, COUNT, COMPARE, DONE);
  - default parameter constants.
- Sub-module `ro_edge_counter`, instantiated twice. It contains:
  - the 2-flop synchronizer, edge detect and counter;
  - `clr` and `cnt_en` inputs;
  - saturation controlled by `RO_PUF_SAT_EN`.

## Test plan
- Fast vs slow: RO a has period 10 clk and RO b period 14 clk, with `win_cycles`=1400. Required: `cnt_a`≈140, `cnt_b`≈100 (±1), `response`=1, `done` at T+SETTLE_CYC+1402, only two `ro_en` bits high during the run.
- Swapped selects from the same setup: `response`=0. Equal periods of 12 clk with phases aligned: equal counts and `response`=0.
- Illegal requests:
  - `sel_a`=`sel_b`=3: `done` and `err` at T+1, `ro_en` never nonzero, `response`=0.
  - `sel_a`=NUM_RO: same response.
- Zero window, `win_cycles`=0: `cnt_a`=`cnt_b`=0, `response`=0, `done` at T+SETTLE_CYC+2.
- Saturation: CNT_W=4, RO a period 4 clk, `win_cycles`=200. Required: `cnt_a`=15 with `RO_PUF_SAT_EN` defined, and the wrapped value without it.
- Reset and ignored start:
  - `rst` asserted during COUNT: next cycle `ro_en`=0, `busy`=0, outputs at reset values.
  - `start` pulsed while `busy`: ignored, and the original result is unchanged.
